step_motor_sequencer: RTL and testbench

- Motion controller placed in front of the three-phase step motor driver.
- Accepts move commands (direction, step count, step period) over a valid/ready handshake.
- Emits one-cycle step strobes plus the direction level `m` that feeds the driver's M input.
- Tracks absolute position and inserts a settle delay on every direction reversal.

---
 rtl/step_motor_sequencer.sv | 150 +++++++++++++++
 tb/tb_step_motor_sequencer.sv | 255 +++++++++++++++++++++++++
 2 files changed

// File: rtl/step_motor_sequencer.sv
// Step/direction motion sequencer: accepts move commands, paces step strobes at a
// programmable period, tracks absolute position and settles on direction reversal.
module step_motor_sequencer #(
    parameter int CNT_W  = 16,
    parameter int DIV_W  = 16,
    parameter int POS_W  = 16,
    parameter int SETTLE = 8
) (
    input  logic             clk,
    input  logic             cr,
    input  logic             cmd_valid,
    output logic             cmd_ready,
    input  logic             cmd_dir,
    input  logic [CNT_W-1:0] cmd_steps,
    input  logic [DIV_W-1:0] cmd_period,
    input  logic             abort,
    output logic             step,
    output logic             m,
    output logic             busy,
    output logic             done,
    output logic             aborted,
    output logic [POS_W-1:0] pos,
    output logic [CNT_W-1:0] steps_left
);

    localparam int SET_W = (SETTLE > 1) ? $clog2(SETTLE) : 1;
    localparam logic [SET_W-1:0] SETTLE_M1 = SET_W'(SETTLE - 1);

    typedef enum logic [1:0] {S_IDLE, S_SETTLE, S_RUN, S_DONE} state_t;

    state_t           r_state;
    logic             r_ready;
    logic             r_step;
    logic             r_m;
    logic             r_busy;
    logic             r_done;
    logic             r_aborted;
    logic [POS_W-1:0] r_pos;
    logic [CNT_W-1:0] r_steps_left;
    logic [DIV_W-1:0] r_period_m1;
    logic [DIV_W-1:0] r_per_cnt;
    logic [SET_W-1:0] r_settle_cnt;

    logic [DIV_W-1:0] w_period_m1;
    logic [POS_W-1:0] w_pos_next;

    // A zero period is treated as one cycle per step.
    assign w_period_m1 = (cmd_period == '0) ? '0 : cmd_period - DIV_W'(1);
    assign w_pos_next  = r_m ? r_pos + POS_W'(1) : r_pos - POS_W'(1);

    // NOTE: every register here is updated with <= so all state advances from the
    // same pre-edge snapshot; blocking assignments would leak new values mid-block.
    always_ff @(posedge clk or negedge cr) begin
        if (!cr) begin
            r_state      <= S_IDLE;
            r_ready      <= 1'b1;
            r_step       <= 1'b0;
            r_m          <= 1'b0;
            r_busy       <= 1'b0;
            r_done       <= 1'b0;
            r_aborted    <= 1'b0;
            r_pos        <= '0;
            r_steps_left <= '0;
            r_period_m1  <= '0;
            r_per_cnt    <= '0;
            r_settle_cnt <= '0;
        end else begin
            r_step <= 1'b0;
            case (r_state)
                S_IDLE: begin
                    if (cmd_valid) begin
                        r_ready      <= 1'b0;
                        r_steps_left <= cmd_steps;
                        r_period_m1  <= w_period_m1;
                        r_per_cnt    <= w_period_m1;
                        if (cmd_steps == '0) begin
                            r_state <= S_DONE;
                            r_done  <= 1'b1;
                        end else if (cmd_dir != r_m) begin
                            r_m          <= cmd_dir;
                            r_state      <= S_SETTLE;
                            r_settle_cnt <= SETTLE_M1;
                            r_busy       <= 1'b1;
                        end else begin
                            r_state <= S_RUN;
                            r_busy  <= 1'b1;
                        end
                    end
                end
                S_SETTLE: begin
                    if (abort) begin
                        r_state   <= S_DONE;
                        r_busy    <= 1'b0;
                        r_done    <= 1'b1;
                        r_aborted <= 1'b1;
                    end else if (r_settle_cnt == '0) begin
                        r_state   <= S_RUN;
                        r_per_cnt <= r_period_m1;
                    end else begin
                        r_settle_cnt <= r_settle_cnt - SET_W'(1);
                    end
                end
                S_RUN: begin
                    if (abort) begin
                        r_state   <= S_DONE;
                        r_busy    <= 1'b0;
                        r_done    <= 1'b1;
                        r_aborted <= 1'b1;
                    end else if (r_per_cnt == '0) begin
                        r_step       <= 1'b1;
                        r_steps_left <= r_steps_left - CNT_W'(1);
                        r_pos        <= w_pos_next;
                        r_per_cnt    <= r_period_m1;
                        // Final step: done follows one cycle later, as the strobe drops.
                        if (r_steps_left == CNT_W'(1)) begin
                            r_state <= S_DONE;
                            r_busy  <= 1'b0;
                        end
                    end else begin
                        r_per_cnt <= r_per_cnt - DIV_W'(1);
                    end
                end
                S_DONE: begin
                    if (r_done) begin
                        r_state   <= S_IDLE;
                        r_done    <= 1'b0;
                        r_aborted <= 1'b0;
                        r_ready   <= 1'b1;
                    end else begin
                        r_done <= 1'b1;
                    end
                end
                default: begin
                    r_state <= S_IDLE;
                    r_ready <= 1'b1;
                end
            endcase
        end
    end

    assign cmd_ready  = r_ready;
    assign step       = r_step;
    assign m          = r_m;
    assign busy       = r_busy;
    assign done       = r_done;
    assign aborted    = r_aborted;
    assign pos        = r_pos;
    assign steps_left = r_steps_left;

endmodule

// File: tb/tb_step_motor_sequencer.sv
// Bench for step_motor_sequencer: a schedule-based model of each accepted command
// checked every cycle, plus directed sequences with literal expectations.
module tb_step_motor_sequencer;

    localparam int SETTLE = 8;

    logic        clk = 1'b0;
    logic        cr = 1'b0;
    logic        cmd_valid = 1'b0;
    logic        cmd_dir = 1'b0;
    logic [15:0] cmd_steps = '0;
    logic [15:0] cmd_period = '0;
    logic        abort = 1'b0;
    logic        cmd_ready, step, m, busy, done, aborted;
    logic [15:0] pos, steps_left;

    always #5 clk = ~clk;

    step_motor_sequencer #(.CNT_W(16), .DIV_W(16), .POS_W(16), .SETTLE(SETTLE)) dut (
        .clk(clk), .cr(cr), .cmd_valid(cmd_valid), .cmd_ready(cmd_ready),
        .cmd_dir(cmd_dir), .cmd_steps(cmd_steps), .cmd_period(cmd_period),
        .abort(abort), .step(step), .m(m), .busy(busy), .done(done),
        .aborted(aborted), .pos(pos), .steps_left(steps_left)
    );

    int tests = 0;
    int fails = 0;
    int cyc = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    task automatic fail_now(input string name);
        tests++;
        fails++;
        $display("FAIL %s: bound expired (cycle %0d)", name, cyc);
    endtask

    // Model: each command is a schedule of edge numbers derived from the rules.
    typedef struct packed {
        logic        step;
        logic        busy;
        logic        done;
        logic        aborted;
        logic        ready;
        logic        m;
        logic [15:0] pos;
        logic [15:0] sl;
    } exp_t;

    bit has_cmd = 1'b0;
    bit m_new = 1'b0;
    bit ab = 1'b0;
    int t_acc, t_run, per, nst, neff, pos0, busy_e, done_e, idle_e;
    int acc_cyc = -1;

    function automatic exp_t exp_at(input int n);
        exp_t e;
        int k, d, p;
        e = '0;
        e.ready = 1'b1;
        if (!has_cmd) return e;
        k = 0;
        d = n - t_run;
        if (d >= 0) k = d / per;
        if (k > neff) k = neff;
        p = m_new ? pos0 + k : pos0 - k;
        e.pos     = 16'(p);
        e.sl      = 16'(nst - k);
        e.m       = m_new;
        e.step    = (d > 0) && (d % per == 0) && (d / per <= neff);
        e.busy    = (n < busy_e);
        e.done    = (n == done_e);
        e.aborted = e.done && ab;
        e.ready   = (n >= idle_e);
        return e;
    endfunction

    always @(posedge clk or negedge cr) begin : model
        exp_t ep;
        if (!cr) begin
            has_cmd = 1'b0;
            cyc = 0;
        end else begin
            ep = exp_at(cyc);
            cyc = cyc + 1;
            if (cmd_valid && ep.ready) begin
                pos0 = int'(ep.pos);
                t_acc = cyc;
                per = (cmd_period == 16'd0) ? 1 : int'(cmd_period);
                nst = int'(cmd_steps);
                ab = 1'b0;
                has_cmd = 1'b1;
                acc_cyc = cyc;
                if (nst == 0) begin
                    m_new = ep.m;
                    t_run = t_acc;
                    neff = 0;
                    busy_e = t_acc;
                    done_e = t_acc;
                    idle_e = t_acc + 1;
                end else begin
                    m_new = cmd_dir;
                    t_run = t_acc + ((cmd_dir != ep.m) ? SETTLE : 0);
                    neff = nst;
                    busy_e = t_run + nst * per;
                    done_e = busy_e + 1;
                    idle_e = busy_e + 2;
                end
            end else if (abort && ep.busy) begin
                neff = (cyc - 1 >= t_run) ? (cyc - 1 - t_run) / per : 0;
                if (neff > nst) neff = nst;
                busy_e = cyc;
                done_e = cyc;
                idle_e = cyc + 1;
                ab = 1'b1;
            end
        end
    end

    always @(negedge clk) begin : compare
        exp_t e;
        if (cr) begin
            e = exp_at(cyc);
            check("cmp_step", step, e.step);
            check("cmp_busy", busy, e.busy);
            check("cmp_done", done, e.done);
            check("cmp_aborted", aborted, e.aborted);
            check("cmp_ready", cmd_ready, e.ready);
            check("cmp_m", m, e.m);
            check("cmp_pos", pos, e.pos);
            check("cmp_steps_left", steps_left, e.sl);
        end
    end

    task automatic wait_cyc(input int target);
        int guard = 0;
        while (cyc != target && guard < 3000) begin
            @(negedge clk);
            guard++;
        end
        if (cyc != target) fail_now("wait_cyc");
    endtask

    task automatic send(input logic dir, input logic [15:0] n, input logic [15:0] p, output int t);
        int guard = 0;
        cmd_dir = dir;
        cmd_steps = n;
        cmd_period = p;
        cmd_valid = 1'b1;
        do begin
            @(negedge clk);
            guard++;
        end while (acc_cyc != cyc && guard < 200);
        cmd_valid = 1'b0;
        if (acc_cyc != cyc) fail_now("accept");
        t = acc_cyc;
    endtask

    initial begin : watchdog
        #300000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    initial begin : stim
        int ta, tb, tc, td, te, tf, tg, th;
        repeat (5) @(negedge clk);
        check("rst_ready", cmd_ready, 1);
        check("rst_pos", pos, 0);
        cr = 1'b1;
        check("rel_m", m, 0);
        check("rel_steps_left", steps_left, 0);
        repeat (20) @(negedge clk);

        // Reversal from reset: settle, then three steps 4 cycles apart.
        send(1'b1, 16'd3, 16'd4, ta);
        check("t2_m", m, 1);
        check("t2_busy", busy, 1);
        wait_cyc(ta + 11); check("t2_no_early_step", step, 0);
        wait_cyc(ta + 12); check("t2_step1", step, 1);
        wait_cyc(ta + 16); check("t2_step2", step, 1);
        wait_cyc(ta + 20); check("t2_step3", step, 1); check("t2_busy_end", busy, 0);
        wait_cyc(ta + 21);
        check("t2_done", done, 1); check("t2_aborted", aborted, 0);
        check("t2_pos", pos, 3); check("t2_step_low", step, 0);
        wait_cyc(ta + 22); check("t2_ready", cmd_ready, 1);

        // Same direction, period 0: no settle, a step every cycle.
        send(1'b1, 16'd2, 16'd0, tb);
        wait_cyc(tb + 1); check("t3_step1", step, 1);
        wait_cyc(tb + 2); check("t3_step2", step, 1);
        wait_cyc(tb + 3); check("t3_done", done, 1); check("t3_pos", pos, 5);
        wait_cyc(tb + 4);

        // Abort while idle does nothing.
        abort = 1'b1; @(negedge clk); abort = 1'b0;
        check("idle_abort_done", done, 0);

        // Reverse, abort the cycle after the second step.
        send(1'b0, 16'd5, 16'd2, tc);
        check("t4_m", m, 0);
        wait_cyc(tc + 10); check("t4_step1", step, 1);
        wait_cyc(tc + 12); check("t4_step2", step, 1);
        abort = 1'b1; @(negedge clk); abort = 1'b0;
        check("t4_done", done, 1); check("t4_aborted", aborted, 1);
        check("t4_pos", pos, 3); check("t4_steps_left", steps_left, 3);
        repeat (4) @(negedge clk);
        check("t4_hold_left", steps_left, 3);

        // Abort on the very edge that would issue a step: abort wins.
        send(1'b0, 16'd3, 16'd1, td);
        wait_cyc(td + 1); check("ab_step1", step, 1); check("ab_pos1", pos, 2);
        abort = 1'b1; @(negedge clk); abort = 1'b0;
        check("ab_no_step", step, 0); check("ab_done", done, 1);
        check("ab_pos", pos, 2); check("ab_left", steps_left, 2);
        wait_cyc(td + 3);

        // Zero-step command with opposite direction: done only, m unchanged.
        send(1'b1, 16'd0, 16'd7, te);
        check("t5_done", done, 1); check("t5_m", m, 0);
        check("t5_pos", pos, 2); check("t5_busy", busy, 0);
        wait_cyc(te + 1); check("t5_ready", cmd_ready, 1);

        // Command held during RUN is taken only once the block is idle again.
        send(1'b0, 16'd2, 16'd3, tf);
        send(1'b0, 16'd1, 16'd1, tg);
        check("t5_held_accept", tg, tf + 9);
        wait_cyc(tg + 1); check("t6_wrap_step", step, 1);
        wait_cyc(tg + 2); check("t6_wrap_pos", pos, 16'hFFFF); check("t6_done", done, 1);
        wait_cyc(tg + 3);

        // Reset pulled mid-RUN, between clock edges.
        send(1'b1, 16'd4, 16'd3, th);
        wait_cyc(th + 14); check("t6_step2", step, 1); check("t6_pos", pos, 1);
        #1 cr = 1'b0;
        #1;
        check("rst_async_step", step, 0); check("rst_async_pos", pos, 0);
        check("rst_async_m", m, 0); check("rst_async_busy", busy, 0);
        check("rst_async_left", steps_left, 0); check("rst_async_ready", cmd_ready, 1);
        repeat (3) @(negedge clk);
        cr = 1'b1;
        repeat (10) @(negedge clk);
        check("post_rst_done", done, 0);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
